mem_delayed: RTL and testbench

//  Word-addressed 16-bit memory responder: the memory end of the proc mem_* interface.

---
 rtl/mem_delayed_if.sv | 31 +++
 rtl/mem_delayed.sv | 159 +++++++++++++++
 tb/tb_mem_delayed.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_delayed_if.sv
// mem_delayed_if
//   Groups the processor-side memory request/response bus so the initiator
//   and the memory responder share one bundle.
//   master modport : the initiator (drives address, write data, request pulses)
//   slave modport  : the memory (drives read data, ack pulse and busy flag)
//   mem_addr     16  word address, sampled with a request
//   mem_wr_data  16  write data, sampled with a request
//   mem_rd_req    1  read request pulse
//   mem_wr_req    1  write request pulse
//   mem_rd_data  16  read data, valid only in the ack cycle of a read
//   mem_ack       1  one-cycle completion pulse
//   mem_busy      1  transaction in flight; requests ignored while high
interface mem_delayed_if;
  logic [15:0] mem_addr;
  logic [15:0] mem_wr_data;
  logic        mem_rd_req;
  logic        mem_wr_req;
  logic [15:0] mem_rd_data;
  logic        mem_ack;
  logic        mem_busy;

  modport master (
    output mem_addr, mem_wr_data, mem_rd_req, mem_wr_req,
    input  mem_rd_data, mem_ack, mem_busy
  );

  modport slave (
    input  mem_addr, mem_wr_data, mem_rd_req, mem_wr_req,
    output mem_rd_data, mem_ack, mem_busy
  );
endinterface

// File: rtl/mem_delayed.sv
// mem_delayed
//   Word-addressed 16-bit memory responder. Each accepted read or write
//   request is answered LATENCY cycles later with a one-cycle ack; busy is
//   held high for the whole transaction and new requests are ignored then.
//   A side-band port lets boot logic or benches preload words at any time.
//   Parameters:
//     DEPTH    number of 16-bit words (valid addresses 0..DEPTH-1)
//     LATENCY  cycles from request accept to ack, 1..15
//   Ports:
//     clk          clock, all logic on posedge
//     rst          synchronous active-high reset
//     bus          mem_delayed_if slave side (request/response bus)
//     oob_wen      side-band write enable
//     oob_addr     side-band write address
//     oob_wr_data  side-band write data
module mem_delayed #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  mem_delayed_if.slave bus,
  input  logic        oob_wen,
  input  logic [15:0] oob_addr,
  input  logic [15:0] oob_wr_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WaitLoad = 4'(LATENCY - 1);

  // The latency counter is 4 bits wide, so anything outside 1..15 cannot
  // be represented and must stop elaboration.
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $fatal(1, "mem_delayed: LATENCY must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q;
  logic [15:0] data_q;
  logic        write_q;
  logic [15:0] rdData_q, rdData_d;
  logic [15:0] mem [DEPTH];

  logic        accept;
  logic        enterAck;
  logic [15:0] txnAddr;
  logic [15:0] txnData;
  logic        txnWrite;
  logic        txnInRange;
  logic        commitWrite;
  logic        oobInRange;

  // While idle, the transaction being accepted on this edge is described by
  // the live bus; afterwards by the latched copy. With LATENCY=1 the accept
  // edge is also the edge entering ACK, so the live values must be used.
  always_comb begin
    accept     = (state_q == IDLE) && (bus.mem_rd_req || bus.mem_wr_req);
    txnAddr    = (state_q == IDLE) ? bus.mem_addr    : addr_q;
    txnData    = (state_q == IDLE) ? bus.mem_wr_data : data_q;
    txnWrite   = (state_q == IDLE) ? bus.mem_wr_req  : write_q;
    txnInRange = {16'd0, txnAddr} < 32'(DEPTH);
    oobInRange = {16'd0, oob_addr} < 32'(DEPTH);
  end

  // Next-state logic. The counter is loaded with LATENCY-1 on accept and
  // the transition to ACK happens when it reaches 1, which places the ack
  // exactly LATENCY cycles after the request cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    enterAck = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d  = ACK;
            enterAck = 1'b1;
            cnt_d    = 4'd0;
          end else begin
            state_d = WAIT;
            cnt_d   = WaitLoad;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d  = ACK;
          enterAck = 1'b1;
          cnt_d    = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Read data is captured on the edge entering ACK, so side-band writes
  // made while waiting are seen. Out-of-range reads and writes return zero.
  always_comb begin
    rdData_d    = 16'd0;
    commitWrite = enterAck && txnWrite && txnInRange;
    if (enterAck && !txnWrite && txnInRange) begin
      rdData_d = mem[txnAddr[AW-1:0]];
    end
  end

  // Control registers; the request is latched only when it is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      rdData_q <= 16'd0;
      addr_q   <= 16'd0;
      data_q   <= 16'd0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdData_q <= rdData_d;
      if (accept) begin
        addr_q  <= bus.mem_addr;
        data_q  <= bus.mem_wr_data;
        write_q <= bus.mem_wr_req;
      end
    end
  end

  // Storage array, never reset. The transaction write is issued after the
  // side-band write so it wins when both hit the same word on one edge.
  // Reset aborts a pending write so it never commits.
  always_ff @(posedge clk) begin
    if (oob_wen && oobInRange) begin
      mem[oob_addr[AW-1:0]] <= oob_wr_data;
    end
    if (!rst && commitWrite) begin
      mem[txnAddr[AW-1:0]] <= txnData;
    end
  end

  assign bus.mem_busy    = (state_q != IDLE);
  assign bus.mem_ack     = (state_q == ACK);
  assign bus.mem_rd_data = rdData_q;

endmodule

// File: tb/tb_mem_delayed.sv
// tb_mem_delayed
//   Drives a LATENCY=3 memory with directed and random traffic while a
//   transaction-level model predicts each ack cycle and read value; a
//   separate monitor compares every cycle against that scoreboard. A second
//   LATENCY=1 instance gets a short directed check.
module tb_mem_delayed;

  localparam int DEPTH = 256;
  localparam int L     = 3;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;

  // Free-running cycle number; the request cycle "N" is read from here.
  always @(posedge clk) cyc <= cyc + 1;

  mem_delayed_if bus0 ();
  mem_delayed_if bus1 ();

  logic        oobWen0, oobWen1;
  logic [15:0] oobAddr0, oobAddr1;
  logic [15:0] oobData0, oobData1;

  mem_delayed #(.DEPTH(DEPTH), .LATENCY(L)) dut0 (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus0),
    .oob_wen     (oobWen0),
    .oob_addr    (oobAddr0),
    .oob_wr_data (oobData0)
  );

  mem_delayed #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus1),
    .oob_wen     (oobWen1),
    .oob_addr    (oobAddr1),
    .oob_wr_data (oobData1)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cycle;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model [DEPTH];

  // Transaction-level model of the single in-flight request.
  bit          pendValid = 1'b0;
  int          pendAcceptCycle;
  int          pendAckCycle;
  bit          pendWrite;
  logic [15:0] pendAddr;
  logic [15:0] pendData;
  bit          expBusy = 1'b0;
  bit          monOn = 1'b0;

  exp_t        monE;
  bit          monExpAck;

  logic [15:0] oor [4] = '{16'd256, 16'd300, 16'hFFFF, 16'd261};

  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // One cycle of stimulus for dut0 plus the model's view of the edge that
  // ends this cycle: what busy looks like now, whether the request is
  // accepted, whether an ack becomes due next cycle, and which writes land.
  task automatic applyStimulus(input logic rdV, input logic wrV,
                               input logic [15:0] aV, input logic [15:0] dV,
                               input logic oW, input logic [15:0] oA,
                               input logic [15:0] oD, input logic rV);
    int          c;
    bit          commit;
    logic [15:0] rdExp;
    @(posedge clk);
    #1;
    c = cyc;
    bus0.mem_rd_req  = rdV;
    bus0.mem_wr_req  = wrV;
    bus0.mem_addr    = aV;
    bus0.mem_wr_data = dV;
    oobWen0  = oW;
    oobAddr0 = oA;
    oobData0 = oD;
    rst      = rV;

    expBusy = pendValid && (c > pendAcceptCycle) && (c <= pendAckCycle);
    commit  = 1'b0;
    if (rV) begin
      pendValid = 1'b0;
    end else begin
      if (pendValid && c == pendAckCycle) pendValid = 1'b0;
      if (!expBusy && (rdV || wrV)) begin
        pendValid       = 1'b1;
        pendAcceptCycle = c;
        pendAckCycle    = c + L;
        pendWrite       = wrV;
        pendAddr        = aV;
        pendData        = dV;
      end
      if (pendValid && pendAckCycle == c + 1) begin
        rdExp = (!pendWrite && int'(pendAddr) < DEPTH) ? model[pendAddr[7:0]] : 16'd0;
        sb.push_back('{c + 1, rdExp});
        commit = pendWrite && (int'(pendAddr) < DEPTH);
      end
    end
    if (oW && int'(oA) < DEPTH) model[oA[7:0]] = oD;
    if (commit) model[pendAddr[7:0]] = pendData;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 16'd0, 16'd0, 0, 16'd0, 16'd0, 0);
  endtask

  // Monitor: every cycle compare busy, ack and read data with the model.
  always @(negedge clk) begin
    if (monOn) begin
      checkOutput("busy", {15'd0, bus0.mem_busy}, {15'd0, expBusy});
      monExpAck = (sb.size() > 0) && (sb[0].cycle == cyc);
      checkOutput("ack", {15'd0, bus0.mem_ack}, {15'd0, monExpAck});
      if (monExpAck) begin
        monE = sb.pop_front();
        checkOutput("ack rd_data", bus0.mem_rd_data, monE.data);
      end else begin
        checkOutput("idle rd_data", bus0.mem_rd_data, 16'd0);
      end
    end
  end

  initial begin
    bit          rdV, wrV, oW, rV;
    logic [15:0] aV, dV, oA, oD;
    int          r;

    rst = 1'b1;
    bus0.mem_rd_req = 0; bus0.mem_wr_req = 0; bus0.mem_addr = 0; bus0.mem_wr_data = 0;
    bus1.mem_rd_req = 0; bus1.mem_wr_req = 0; bus1.mem_addr = 0; bus1.mem_wr_data = 0;
    oobWen0 = 0; oobAddr0 = 0; oobData0 = 0;
    oobWen1 = 0; oobAddr1 = 0; oobData1 = 0;

    applyStimulus(0, 0, 16'd0, 16'd0, 0, 16'd0, 16'd0, 1);
    applyStimulus(0, 0, 16'd0, 16'd0, 0, 16'd0, 16'd0, 1);
    checkOutput("reset busy", {15'd0, bus0.mem_busy}, 16'd0);
    checkOutput("reset ack", {15'd0, bus0.mem_ack}, 16'd0);
    checkOutput("reset rd_data", bus0.mem_rd_data, 16'd0);
    monOn = 1'b1;

    // Preload the lower words so random reads have known contents.
    for (int i = 0; i < 64; i++)
      applyStimulus(0, 0, 16'd0, 16'd0, 1, 16'(i), 16'($urandom), 0);

    $display("[TB] directed sequences");
    applyStimulus(0, 0, 16'd0, 16'd0, 1, 16'd5, 16'h0305, 0);
    applyStimulus(1, 0, 16'd5, 16'd0, 0, 16'd0, 16'd0, 0);
    idle(4);
    applyStimulus(0, 1, 16'd7, 16'hBEEF, 0, 16'd0, 16'd0, 0);
    idle(3);
    applyStimulus(1, 0, 16'd7, 16'd0, 0, 16'd0, 16'd0, 0);
    idle(4);
    applyStimulus(1, 0, 16'd5, 16'd0, 0, 16'd0, 16'd0, 0);
    idle(1);
    applyStimulus(1, 0, 16'd6, 16'd0, 0, 16'd0, 16'd0, 0);
    idle(6);
    applyStimulus(1, 1, 16'd9, 16'h1234, 0, 16'd0, 16'd0, 0);
    idle(3);
    applyStimulus(1, 0, 16'd9, 16'd0, 0, 16'd0, 16'd0, 0);
    idle(4);
    applyStimulus(0, 1, 16'd10, 16'hAAAA, 0, 16'd0, 16'd0, 0);
    idle(1);
    applyStimulus(0, 0, 16'd0, 16'd0, 0, 16'd0, 16'd0, 1);
    idle(3);
    applyStimulus(1, 0, 16'd10, 16'd0, 0, 16'd0, 16'd0, 0);
    idle(4);
    applyStimulus(1, 0, 16'd300, 16'd0, 0, 16'd0, 16'd0, 0);
    idle(3);
    applyStimulus(0, 1, 16'd300, 16'h5A5A, 0, 16'd0, 16'd0, 0);
    idle(3);
    applyStimulus(1, 0, 16'd44, 16'd0, 0, 16'd0, 16'd0, 0);
    idle(4);
    // Side-band write while a read of the same word waits.
    applyStimulus(1, 0, 16'd20, 16'd0, 0, 16'd0, 16'd0, 0);
    applyStimulus(0, 0, 16'd0, 16'd0, 1, 16'd20, 16'hCAFE, 0);
    idle(3);
    // Side-band write on the same edge as a committing write.
    applyStimulus(0, 1, 16'd21, 16'h1111, 0, 16'd0, 16'd0, 0);
    idle(1);
    applyStimulus(0, 0, 16'd0, 16'd0, 1, 16'd21, 16'h2222, 0);
    idle(1);
    applyStimulus(1, 0, 16'd21, 16'd0, 0, 16'd0, 16'd0, 0);
    idle(4);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      r   = $urandom_range(0, 7);
      rdV = (r == 0 || r == 1 || r == 7);
      wrV = (r == 2 || r == 7);
      aV  = ($urandom_range(0, 9) == 0) ? oor[$urandom_range(0, 3)] : 16'($urandom_range(0, 63));
      dV  = 16'($urandom);
      oW  = ($urandom_range(0, 3) == 0);
      oA  = ($urandom_range(0, 9) == 0) ? 16'd300 : 16'($urandom_range(0, 63));
      oD  = 16'($urandom);
      rV  = ($urandom_range(0, 149) == 0);
      applyStimulus(rdV, wrV, aV, dV, oW, oA, oD, rV);
    end
    idle(L + 2);

    $display("[TB] LATENCY=1 instance");
    applyStimulus(0, 0, 16'd0, 16'd0, 0, 16'd0, 16'd0, 0);
    oobWen1 = 1; oobAddr1 = 16'd3; oobData1 = 16'h1111;
    applyStimulus(0, 0, 16'd0, 16'd0, 0, 16'd0, 16'd0, 0);
    oobWen1 = 0;
    bus1.mem_rd_req = 1; bus1.mem_addr = 16'd3;
    checkOutput("lat1 busy N", {15'd0, bus1.mem_busy}, 16'd0);
    applyStimulus(0, 0, 16'd0, 16'd0, 0, 16'd0, 16'd0, 0);
    bus1.mem_rd_req = 0;
    checkOutput("lat1 busy N+1", {15'd0, bus1.mem_busy}, 16'd1);
    checkOutput("lat1 ack N+1", {15'd0, bus1.mem_ack}, 16'd1);
    checkOutput("lat1 rd_data N+1", bus1.mem_rd_data, 16'h1111);
    applyStimulus(0, 0, 16'd0, 16'd0, 0, 16'd0, 16'd0, 0);
    checkOutput("lat1 busy N+2", {15'd0, bus1.mem_busy}, 16'd0);
    checkOutput("lat1 ack N+2", {15'd0, bus1.mem_ack}, 16'd0);
    checkOutput("lat1 rd_data N+2", bus1.mem_rd_data, 16'd0);

    idle(2);
    monOn = 1'b0;
    checkOutput("scoreboard drained", 16'(sb.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
